// File: rtl/ws2811_frame_scheduler.sv
// Frame owner for the WS2811 sender: arbitrated pixel writes into a working buffer,
// periodic snapshot into the shadow frame, sender start/handshake and status flags.
module ws2811_frame_scheduler #(
  parameter int NUM_LEDS     = 20,
  parameter int FRAME_PERIOD = 200000,
  parameter int BUSY_TIMEOUT = 64,
  parameter int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req,
  input  logic [IDX_W-1:0]       a_idx,
  input  logic [23:0]            a_rgb,
  output logic                   a_gnt,
  input  logic                   b_req,
  input  logic [IDX_W-1:0]       b_idx,
  input  logic [23:0]            b_rgb,
  output logic                   b_gnt,
  output logic [NUM_LEDS*24-1:0] frame_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [15:0]            frame_count,
  output logic                   overrun,
  output logic                   err_idx,
  output logic                   err_timeout
);

  localparam int TICK_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int TO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W + 1)'(NUM_LEDS);

  typedef enum logic [2:0] {
    WAIT_TICK,
    LATCH,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic                       prio_b;
  logic [TICK_W-1:0]          tick_cnt;
  logic                       tick;
  logic [TO_W-1:0]            to_cnt;
  logic                       to_hit;
  logic                       done;
  logic [NUM_LEDS-1:0][23:0]  work_buf;
  logic                       wr_en;
  logic                       wr_ok;
  logic [IDX_W-1:0]           wr_idx;
  logic [23:0]                wr_rgb;

  // prio_b set means B wins the next contested cycle
  assign a_gnt  = a_req & (~b_req | ~prio_b);
  assign b_gnt  = b_req & (~a_req | prio_b);
  assign wr_en  = a_gnt | b_gnt;
  assign wr_idx = b_gnt ? b_idx : a_idx;
  assign wr_rgb = b_gnt ? b_rgb : a_rgb;
  assign wr_ok  = wr_en && ({1'b0, wr_idx} < IDX_LIMIT);
  assign err_idx = wr_en && !wr_ok;

  assign tick   = (tick_cnt == TICK_LAST);
  assign to_hit = (state == WAIT_BUSY) && !tx_busy && (to_cnt == TO_LAST);
  assign done   = (state == WAIT_DONE) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_TICK;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_TICK: if (tick) state_next = LATCH;
      LATCH:     state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)              state_next = WAIT_DONE;
        else if (to_cnt == TO_LAST) state_next = WAIT_TICK;
      end
      // entry required tx_busy high, so a low level here is the falling edge
      WAIT_DONE: if (!tx_busy) state_next = WAIT_TICK;
      default:   state_next = WAIT_TICK;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    if (state == START) tx_start = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      to_cnt      <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      err_timeout <= 1'b0;
      prio_b      <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (state == START)          to_cnt <= '0;
      else if (state == WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
      if (done)   frame_count <= frame_count + 16'd1;
      // ticks outside WAIT_TICK are dropped, only flagged
      if (tick && state != WAIT_TICK) overrun <= 1'b1;
      if (to_hit) err_timeout <= 1'b1;
      if (a_req && b_req) prio_b <= a_gnt;
    end
  end

  // the snapshot takes the buffer as it was before this edge's write
  always_ff @(posedge clk) begin
    if (rst) begin
      work_buf   <= '0;
      frame_data <= '0;
    end else begin
      if (wr_ok)          work_buf[wr_idx] <= wr_rgb;
      if (state == LATCH) frame_data       <= work_buf;
    end
  end

endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// Directed bench for ws2811_frame_scheduler with a short frame period (100 cycles).
module tb_ws2811_frame_scheduler;

  localparam int NUM_LEDS = 20;
  localparam int FW       = NUM_LEDS * 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req;
  logic [4:0]    a_idx, b_idx;
  logic [23:0]   a_rgb, b_rgb;
  logic          a_gnt, b_gnt;
  logic [FW-1:0] frame_data;
  logic          tx_start;
  logic          tx_busy;
  logic [15:0]   frame_count;
  logic          overrun, err_idx, err_timeout;

  int vectors    = 0;
  int miscompares = 0;
  int n          = 0;
  int starts     = 0;
  logic [FW-1:0] exp1, exp2;

  ws2811_frame_scheduler #(
    .NUM_LEDS(NUM_LEDS),
    .FRAME_PERIOD(100),
    .BUSY_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a_req(a_req),
    .a_idx(a_idx),
    .a_rgb(a_rgb),
    .a_gnt(a_gnt),
    .b_req(b_req),
    .b_idx(b_idx),
    .b_rgb(b_rgb),
    .b_gnt(b_gnt),
    .frame_data(frame_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .frame_count(frame_count),
    .overrun(overrun),
    .err_idx(err_idx),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_start(input int limit);
    while (!tx_start && n < limit) step();
  endtask

  initial begin
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_idx = '0; b_idx = '0;
    a_rgb = '0; b_rgb = '0; tx_busy = 1'b0;
    exp1 = '0;
    exp1[3*24 +: 24] = 24'h00FF00;
    exp1[5*24 +: 24] = 24'h222222;
    exp2 = exp1;
    exp2[7*24 +: 24] = 24'h0000AA;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_frame_data", frame_data, 0);

    rst = 1'b0; n = 0;
    a_req = 1'b1; a_idx = 5'd3; a_rgb = 24'h00FF00;
    #1;
    check("a_only_gnt", a_gnt, 1);
    check("a_only_b_gnt", b_gnt, 0);
    check("a_only_err_idx", err_idx, 0);
    step();

    a_idx = 5'd5; a_rgb = 24'h111111;
    b_req = 1'b1; b_idx = 5'd5; b_rgb = 24'h222222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_a_gnt_%0d", i), a_gnt, (i % 2 == 0));
      check($sformatf("rr_b_gnt_%0d", i), b_gnt, (i % 2 == 1));
      step();
    end

    a_req = 1'b0; b_idx = 5'd20; b_rgb = 24'hABCDEF;
    #1;
    check("bad_idx_gnt", b_gnt, 1);
    check("bad_idx_err", err_idx, 1);
    step();
    b_req = 1'b0;
    #1;
    check("err_idx_pulse_end", err_idx, 0);

    wait_start(300);
    check("start1_cycle", n, 101);
    check("frame1_data", frame_data, exp1);
    step();
    check("start1_one_cycle", tx_start, 0);
    tx_busy = 1'b1;
    repeat (20) step();
    check("count_while_busy", frame_count, 0);
    tx_busy = 1'b0;
    step();
    check("count_after_drop", frame_count, 1);
    check("no_overrun_yet", overrun, 0);

    while (n < 200) step();
    a_req = 1'b1; a_idx = 5'd7; a_rgb = 24'h0000AA;
    step();
    a_req = 1'b0; tx_busy = 1'b1;
    check("start2_cycle", tx_start, 1);
    check("latch_excludes_same_cycle", frame_data, exp1);

    starts = 0;
    repeat (150) begin
      step();
      if (tx_start) starts++;
    end
    check("no_stray_start", starts, 0);
    check("overrun_set", overrun, 1);
    check("count_long_busy", frame_count, 1);
    tx_busy = 1'b0;
    step();
    check("count_frame2", frame_count, 2);

    wait_start(600);
    check("start3_cycle", n, 401);
    check("frame3_data", frame_data, exp2);
    check("overrun_sticky", overrun, 1);

    while (n < 465) step();
    check("timeout_not_yet", err_timeout, 0);
    step();
    check("timeout_set", err_timeout, 1);
    check("timeout_not_counted", frame_count, 2);

    wait_start(700);
    check("restart_after_timeout", n, 501);

    rst = 1'b1;
    step();
    check("rst2_err_timeout", err_timeout, 0);
    check("rst2_overrun", overrun, 0);
    check("rst2_frame_count", frame_count, 0);
    check("rst2_tx_start", tx_start, 0);
    check("rst2_frame_data", frame_data, 0);

    rst = 1'b0; n = 0;
    wait_start(300);
    check("start_after_rst", n, 101);
    check("buffer_cleared", frame_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
